// File: rtl/counter_pkg.sv
// Shared types and helpers for the up/down counter family.
package counter_pkg;

  typedef enum logic {CNT_WRAP, CNT_SAT} cnt_mode_t;

  function automatic longint unsigned clamp(input longint unsigned v,
                                            input longint unsigned lo,
                                            input longint unsigned hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/counter_updn_next.sv
// Combinational next-count and boundary calculator for counter_updn_mod.
module counter_updn_next
  import counter_pkg::*;
#(
  parameter int          WIDTH   = 8,
  parameter int unsigned MIN_VAL = 0,
  parameter int unsigned MAX_VAL = 2**WIDTH-1,
  parameter int unsigned STEP    = 1,
  parameter cnt_mode_t   MODE    = CNT_WRAP
) (
  input  logic [WIDTH-1:0] cnt,
  input  logic             dir,
  output logic [WIDTH-1:0] next_cnt,
  output logic             bnd
);

  localparam logic [WIDTH:0] MIN_X   = (WIDTH+1)'(MIN_VAL);
  localparam logic [WIDTH:0] MAX_X   = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0] STEP_X  = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0] RANGE_X = (WIDTH+1)'(MAX_VAL - MIN_VAL + 1);

  // One extra bit keeps the overshoot visible; the down path treats it as a sign bit.
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign sum  = {1'b0, cnt} + STEP_X;
  assign diff = {1'b0, cnt} - STEP_X;

  always_comb begin
    next_cnt = cnt;
    bnd      = 1'b0;
    if (dir) begin
      if (sum <= MAX_X) begin
        next_cnt = sum[WIDTH-1:0];
      end else begin
        bnd      = 1'b1;
        next_cnt = (MODE == CNT_SAT) ? MAX_X[WIDTH-1:0] : WIDTH'(sum - RANGE_X);
      end
    end else begin
      if ($signed(diff) >= $signed(MIN_X)) begin
        next_cnt = diff[WIDTH-1:0];
      end else begin
        bnd      = 1'b1;
        next_cnt = (MODE == CNT_SAT) ? MIN_X[WIDTH-1:0] : WIDTH'(diff + RANGE_X);
      end
    end
  end

endmodule

// File: rtl/counter_updn_mod.sv
// Parametrised up/down counter with wrap or saturate boundaries, boundary pulse and sticky overflow.
// Define COUNTER_CHK_EN to compile in the built-in property checks.
module counter_updn_mod
  import counter_pkg::*;
#(
  parameter int          WIDTH   = 8,
  parameter int unsigned MIN_VAL = 0,
  parameter int unsigned MAX_VAL = 2**WIDTH-1,
  parameter int unsigned STEP    = 1,
  parameter cnt_mode_t   MODE    = CNT_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             dir,
  output logic [WIDTH-1:0] cnt,
  output logic             at_max,
  output logic             at_min,
  output logic             bnd_p,
  output logic             ovf_sticky
);

  localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

  if (MIN_VAL >= MAX_VAL || STEP < 1 || STEP > MAX_VAL - MIN_VAL ||
      (64'(MAX_VAL) >> WIDTH) != 64'd0) begin : g_bad_params
    $fatal(1, "counter_updn_mod: illegal WIDTH/MIN_VAL/MAX_VAL/STEP combination");
  end

  logic [WIDTH-1:0] next_cnt;
  logic             bnd;

  counter_updn_next #(
    .WIDTH  (WIDTH),
    .MIN_VAL(MIN_VAL),
    .MAX_VAL(MAX_VAL),
    .STEP   (STEP),
    .MODE   (MODE)
  ) u_next (
    .cnt     (cnt),
    .dir     (dir),
    .next_cnt(next_cnt),
    .bnd     (bnd)
  );

  // Priority is clr > load > en; bnd_p only survives the edge that caused it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= MIN_W;
      bnd_p      <= 1'b0;
      ovf_sticky <= 1'b0;
    end else if (clr) begin
      cnt        <= MIN_W;
      bnd_p      <= 1'b0;
      ovf_sticky <= 1'b0;
    end else if (load) begin
      cnt   <= WIDTH'(clamp(64'(load_val), 64'(MIN_VAL), 64'(MAX_VAL)));
      bnd_p <= 1'b0;
    end else if (en) begin
      cnt   <= next_cnt;
      bnd_p <= bnd;
      if (bnd) ovf_sticky <= 1'b1;
    end else begin
      bnd_p <= 1'b0;
    end
  end

  assign at_max = (cnt == MAX_W);
  assign at_min = (cnt == MIN_W);

`ifdef COUNTER_CHK_EN
  logic step_up;
  logic step_dn;
  assign step_up = en && !clr && !load && dir;
  assign step_dn = en && !clr && !load && !dir;

  a_known: assert property (@(posedge clk) disable iff (rst) !$isunknown(cnt))
    else $display("counter_updn_mod: cnt unknown");
  a_range: assert property (@(posedge clk) disable iff (rst) cnt >= MIN_W && cnt <= MAX_W)
    else $display("counter_updn_mod: cnt out of range");
  a_up: assert property (@(posedge clk) disable iff (rst)
                         step_up ##1 !bnd_p |-> cnt == WIDTH'($past(cnt) + STEP))
    else $display("counter_updn_mod: bad up step");
  a_dn: assert property (@(posedge clk) disable iff (rst)
                         step_dn ##1 !bnd_p |-> cnt == WIDTH'($past(cnt) - STEP))
    else $display("counter_updn_mod: bad down step");
  // Wrap mode with a large STEP can legitimately overshoot on consecutive steps.
  a_bnd2: assert property (@(posedge clk) disable iff (rst)
                           (MODE == CNT_SAT) && bnd_p && $past(bnd_p) |->
                           $past((step_up && at_max) || (step_dn && at_min)))
    else $display("counter_updn_mod: bnd_p held outside a limit");
  a_ovf: assert property (@(posedge clk) disable iff (rst) $fell(ovf_sticky) |-> $past(clr))
    else $display("counter_updn_mod: ovf_sticky fell without clr");
`endif

endmodule

// File: tb/tb_counter_updn_mod.sv
// Self-checking bench: five counter configurations share one stimulus stream.
module tb_counter_updn_mod;
  import counter_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'd0;
  logic       en = 1'b0;
  logic       dir = 1'b0;

  logic [7:0] cnt_o [5];
  logic [3:0] cnt_e;
  logic       at_max_o [5];
  logic       at_min_o [5];
  logic       bnd_o [5];
  logic       ovf_o [5];

  int checks = 0;
  int failures = 0;

  // Instance configs: 0..9/1 wrap, 0..9/1 sat, 2..11/3 wrap, 2..11/3 sat, 4-bit full range /5 wrap
  int p_min  [5] = '{0, 0, 2, 2, 0};
  int p_max  [5] = '{9, 9, 11, 11, 15};
  int p_step [5] = '{1, 1, 3, 3, 5};
  int p_sat  [5] = '{0, 1, 0, 1, 0};
  int p_mask [5] = '{255, 255, 255, 255, 15};
  int m_cnt [5];
  int m_bnd [5];
  int m_ovf [5];

  always #5 clk = ~clk;

  counter_updn_mod #(.WIDTH(8), .MIN_VAL(0), .MAX_VAL(9), .STEP(1), .MODE(CNT_WRAP)) u_a (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val), .en(en), .dir(dir),
    .cnt(cnt_o[0]), .at_max(at_max_o[0]), .at_min(at_min_o[0]), .bnd_p(bnd_o[0]), .ovf_sticky(ovf_o[0]));
  counter_updn_mod #(.WIDTH(8), .MIN_VAL(0), .MAX_VAL(9), .STEP(1), .MODE(CNT_SAT)) u_b (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val), .en(en), .dir(dir),
    .cnt(cnt_o[1]), .at_max(at_max_o[1]), .at_min(at_min_o[1]), .bnd_p(bnd_o[1]), .ovf_sticky(ovf_o[1]));
  counter_updn_mod #(.WIDTH(8), .MIN_VAL(2), .MAX_VAL(11), .STEP(3), .MODE(CNT_WRAP)) u_c (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val), .en(en), .dir(dir),
    .cnt(cnt_o[2]), .at_max(at_max_o[2]), .at_min(at_min_o[2]), .bnd_p(bnd_o[2]), .ovf_sticky(ovf_o[2]));
  counter_updn_mod #(.WIDTH(8), .MIN_VAL(2), .MAX_VAL(11), .STEP(3), .MODE(CNT_SAT)) u_d (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val), .en(en), .dir(dir),
    .cnt(cnt_o[3]), .at_max(at_max_o[3]), .at_min(at_min_o[3]), .bnd_p(bnd_o[3]), .ovf_sticky(ovf_o[3]));
  counter_updn_mod #(.WIDTH(4), .STEP(5), .MODE(CNT_WRAP)) u_e (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val[3:0]), .en(en), .dir(dir),
    .cnt(cnt_e), .at_max(at_max_o[4]), .at_min(at_min_o[4]), .bnd_p(bnd_o[4]), .ovf_sticky(ovf_o[4]));

  assign cnt_o[4] = {4'b0000, cnt_e};

  task automatic apply_stimulus(input logic c, input logic l, input int lv,
                                input logic e, input logic d);
    clr = c; load = l; load_val = 8'(lv); en = e; dir = d;
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour: ranges treated as modular arithmetic on plain integers
  task automatic model_step(input logic c, input logic l, input int lv,
                            input logic e, input logic d);
    for (int i = 0; i < 5; i++) begin
      int r, t, v;
      r = p_max[i] - p_min[i] + 1;
      if (c) begin
        m_cnt[i] = p_min[i]; m_bnd[i] = 0; m_ovf[i] = 0;
      end else if (l) begin
        v = lv & p_mask[i];
        m_cnt[i] = (v < p_min[i]) ? p_min[i] : ((v > p_max[i]) ? p_max[i] : v);
        m_bnd[i] = 0;
      end else if (e) begin
        t = d ? m_cnt[i] + p_step[i] : m_cnt[i] - p_step[i];
        if (t > p_max[i] || t < p_min[i]) begin
          m_bnd[i] = 1; m_ovf[i] = 1;
          if (p_sat[i] != 0) m_cnt[i] = d ? p_max[i] : p_min[i];
          else m_cnt[i] = p_min[i] + (((t - p_min[i]) % r) + r) % r;
        end else begin
          m_cnt[i] = t; m_bnd[i] = 0;
        end
      end else begin
        m_bnd[i] = 0;
      end
    end
  endtask

  task automatic test_reset();
    #12;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (int'(cnt_o[i]) !== p_min[i] || bnd_o[i] !== 1'b0 || ovf_o[i] !== 1'b0 ||
          at_min_o[i] !== 1'b1 || at_max_o[i] !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset inst%0d: cnt=%0d bnd=%b ovf=%b min=%b max=%b, want cnt=%0d 0 0 1 0",
                 i, cnt_o[i], bnd_o[i], ovf_o[i], at_min_o[i], at_max_o[i], p_min[i]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_wrap_up();
    apply_stimulus(1, 0, 0, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      apply_stimulus(0, 0, 0, 1, 1);
      checks++;
      if (int'(cnt_o[0]) !== k % 10 || bnd_o[0] !== (k == 10)) begin
        failures++;
        $display("[TB] FAIL wrap_up step%0d: cnt=%0d bnd=%b, want cnt=%0d bnd=%b",
                 k, cnt_o[0], bnd_o[0], k % 10, k == 10);
      end
    end
    apply_stimulus(0, 0, 0, 0, 1);
    checks++;
    if (ovf_o[0] !== 1'b1 || bnd_o[0] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL wrap_ovf: ovf=%b bnd=%b, want 1 0", ovf_o[0], bnd_o[0]);
    end
  endtask

  task automatic test_sat_up();
    apply_stimulus(1, 0, 0, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      apply_stimulus(0, 0, 0, 1, 1);
      checks++;
      if (int'(cnt_o[1]) !== ((k > 9) ? 9 : k) || bnd_o[1] !== (k >= 10)) begin
        failures++;
        $display("[TB] FAIL sat_up step%0d: cnt=%0d bnd=%b, want cnt=%0d bnd=%b",
                 k, cnt_o[1], bnd_o[1], (k > 9) ? 9 : k, k >= 10);
      end
    end
    checks++;
    if (at_max_o[1] !== 1'b1 || ovf_o[1] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL sat_flags: at_max=%b ovf=%b, want 1 1", at_max_o[1], ovf_o[1]);
    end
  endtask

  task automatic test_step3();
    apply_stimulus(0, 1, 11, 0, 0);
    apply_stimulus(0, 0, 0, 1, 1);
    checks++;
    if (cnt_o[2] !== 8'd4 || bnd_o[2] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL step3_up: cnt=%0d bnd=%b, want 4 1", cnt_o[2], bnd_o[2]);
    end
    apply_stimulus(0, 1, 3, 0, 0);
    apply_stimulus(0, 0, 0, 1, 0);
    checks++;
    if (cnt_o[2] !== 8'd10 || bnd_o[2] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL step3_down: cnt=%0d bnd=%b, want 10 1", cnt_o[2], bnd_o[2]);
    end
  endtask

  task automatic test_priority();
    apply_stimulus(1, 1, 5, 1, 1);
    checks++;
    if (cnt_o[0] !== 8'd0 || ovf_o[0] !== 1'b0 || cnt_o[2] !== 8'd2 || ovf_o[2] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL prio_clr: a=%0d/%b c=%0d/%b, want 0/0 2/0",
               cnt_o[0], ovf_o[0], cnt_o[2], ovf_o[2]);
    end
    apply_stimulus(0, 1, 5, 1, 1);
    checks++;
    if (cnt_o[0] !== 8'd5 || cnt_o[2] !== 8'd5 || bnd_o[0] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL prio_load: a=%0d c=%0d bnd=%b, want 5 5 0", cnt_o[0], cnt_o[2], bnd_o[0]);
    end
  endtask

  task automatic test_clamp();
    apply_stimulus(0, 1, 200, 0, 0);
    checks++;
    if (cnt_o[2] !== 8'd11 || bnd_o[2] !== 1'b0 || at_max_o[2] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL clamp_hi: cnt=%0d bnd=%b max=%b, want 11 0 1", cnt_o[2], bnd_o[2], at_max_o[2]);
    end
    apply_stimulus(0, 1, 0, 0, 0);
    checks++;
    if (cnt_o[2] !== 8'd2 || bnd_o[2] !== 1'b0 || at_min_o[2] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL clamp_lo: cnt=%0d bnd=%b min=%b, want 2 0 1", cnt_o[2], bnd_o[2], at_min_o[2]);
    end
  endtask

  task automatic test_async_reset();
    apply_stimulus(0, 1, 9, 0, 0);
    for (int k = 0; k < 8; k++) apply_stimulus(0, 0, 0, 1, 1);
    checks++;
    if (cnt_o[0] !== 8'd7 || ovf_o[0] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL pre_reset: cnt=%0d ovf=%b, want 7 1", cnt_o[0], ovf_o[0]);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (cnt_o[0] !== 8'd0 || bnd_o[0] !== 1'b0 || ovf_o[0] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL async_reset: cnt=%0d bnd=%b ovf=%b, want 0 0 0", cnt_o[0], bnd_o[0], ovf_o[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    apply_stimulus(0, 0, 0, 1, 1);
    checks++;
    if (cnt_o[0] !== 8'd1) begin
      failures++;
      $display("[TB] FAIL resume: cnt=%0d, want 1", cnt_o[0]);
    end
  endtask

  task automatic test_random();
    logic c, l, e, d;
    int lv;
    apply_stimulus(1, 0, 0, 0, 0);
    model_step(1, 0, 0, 0, 0);
    for (int n = 0; n < 400; n++) begin
      c  = ($urandom_range(0, 29) == 0);
      l  = ($urandom_range(0, 7) == 0);
      e  = ($urandom_range(0, 3) != 0);
      d  = 1'($urandom_range(0, 1));
      lv = $urandom_range(0, 255);
      apply_stimulus(c, l, lv, e, d);
      model_step(c, l, lv, e, d);
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (int'(cnt_o[i]) !== m_cnt[i] || bnd_o[i] !== 1'(m_bnd[i]) || ovf_o[i] !== 1'(m_ovf[i]) ||
            at_max_o[i] !== (m_cnt[i] == p_max[i]) || at_min_o[i] !== (m_cnt[i] == p_min[i])) begin
          failures++;
          $display("[TB] FAIL random n%0d inst%0d: cnt=%0d bnd=%b ovf=%b max=%b min=%b, want cnt=%0d bnd=%0d ovf=%0d",
                   n, i, cnt_o[i], bnd_o[i], ovf_o[i], at_max_o[i], at_min_o[i],
                   m_cnt[i], m_bnd[i], m_ovf[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_sat_up();
    test_step3();
    test_priority();
    test_clamp();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
